// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction fetch memory: state encoding,
// default parameter values and the byte-offset width.
package instr_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_BYTE_ADDR = 1;
    localparam int BYTE_OFF_W    = 2;

endpackage

// File: rtl/instr_mem_ram.sv
// Word storage with one byte-enabled write port and one registered read port.
// A read and write to the same index on one edge returns the merged (new) word.
module instr_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_widx,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wbe,
    input  logic                i_re,
    input  logic [IDX_W-1:0]    i_ridx,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rd_word;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // Storage has no reset; it is zeroed by the owner's clear sweep.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we && i_wbe[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    always_comb begin
        w_rd_word = r_mem[i_ridx];
        if (i_we && (i_widx == i_ridx)) w_rd_word = merge_bytes(r_mem[i_ridx], i_wdata, i_wbe);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    r_rdata <= '0;
        else if (i_re) r_rdata <= w_rd_word;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port and a byte-enabled program
// port; memory is swept to zero after every reset before fetches are accepted.
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BYTE_ADDR = DEF_BYTE_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [DATA_W-1:0]   prog_data,
    input  logic [DATA_W/8-1:0] prog_be,
    output logic                init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = (BYTE_ADDR != 0) ? BYTE_OFF_W : 0;
    localparam int BE_W  = DATA_W / 8;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    // Anything above the index field, or a nonzero byte offset, is an error.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] hi;
        hi = a >> (IDX_W + OFF_W);
        return (hi != '0) || ((BYTE_ADDR != 0) && (a[BYTE_OFF_W-1:0] != '0));
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_clr_cnt;
    logic                w_clr_last;

    logic                r_rsp_valid;
    logic                r_rsp_err;

    logic                w_req_err;
    logic                w_prog_err;
    logic                w_accept;
    logic                w_rd_en;
    logic [IDX_W-1:0]    w_req_idx;
    logic [IDX_W-1:0]    w_prog_idx;

    logic                w_wr_en;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [DATA_W-1:0]   w_wr_data;
    logic [BE_W-1:0]     w_wr_be;
    logic [DATA_W-1:0]   w_ram_rdata;

    assign w_clr_last = (r_clr_cnt == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= CLEAR;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (w_clr_last) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        init_done = (r_state == RUN);
        req_ready = (r_state == RUN) && (!r_rsp_valid || rsp_ready);
    end

    // Counter parks on the last index so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 r_clr_cnt <= '0;
        else if ((r_state == CLEAR) && !w_clr_last) r_clr_cnt <= r_clr_cnt + IDX_W'(1);
    end

    assign w_req_err  = addr_err(req_addr);
    assign w_prog_err = addr_err(prog_addr);
    assign w_req_idx  = addr_idx(req_addr);
    assign w_prog_idx = addr_idx(prog_addr);
    assign w_accept   = req_valid && req_ready;
    assign w_rd_en    = w_accept && !w_req_err;

    always_comb begin
        if (r_state == CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_clr_cnt;
            w_wr_data = '0;
            w_wr_be   = '1;
        end else begin
            w_wr_en   = prog_we && !w_prog_err;
            w_wr_idx  = w_prog_idx;
            w_wr_data = prog_data;
            w_wr_be   = prog_be;
        end
    end

    instr_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_en),
        .i_widx  (w_wr_idx),
        .i_wdata (w_wr_data),
        .i_wbe   (w_wr_be),
        .i_re    (w_rd_en),
        .i_ridx  (w_req_idx),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register only loads on a non-error accept, so it holds
    // through stalls; the error flag masks it to zero for errored fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_req_err;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_err ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch (DEPTH=16, byte addressing) with a
// response scoreboard filled at request time and drained on each handshake.
module tb_instr_mem_fetch;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [3:0]        prog_be;
    logic              init_done;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_mem_fetch #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BYTE_ADDR (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_be   (prog_be),
        .init_done (init_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responses are consumed on the edge after this negedge sample.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.d));
                chk("rsp_err", 64'(rsp_err), 64'(e.e));
            end
        end
    end

    task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        prog_we = 1'b1; prog_addr = a; prog_data = d; prog_be = be;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
        int n;
        n = 0;
        req_valid = 1'b1; req_addr = a;
        #1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fetch_ready", 64'(req_ready), 64'd1);
        q.push_back('{d: d, e: e});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int   n;
        logic bad;
        n = 0; bad = 1'b0;
        while (!init_done && n < 100) begin
            bad |= req_ready;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_cycles"}, 64'(n), 64'd16);
        chk({tag, "_ready_low"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];

        reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_be = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        // Program attempt during clear must be ignored.
        prog_we = 1'b1; prog_addr = 32'h3C; prog_data = 32'hFFFF_FFFF; prog_be = 4'hF;
        reset = 1'b1;
        wait_init("init1");
        prog_we = 1'b0;
        fetch(32'h3C, 32'h0, 1'b0);
        fetch(32'h00, 32'h0, 1'b0);

        // Program then fetch with one-cycle latency.
        prog(32'h8, 32'hDEAD_BEEF, 4'hF);
        req_addr = 32'h8; req_valid = 1'b1;
        #1;
        chk("lat_ready", 64'(req_ready), 64'd1);
        q.push_back('{d: 32'hDEAD_BEEF, e: 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        chk("rsp_valid_clears", 64'(rsp_valid), 64'd0);

        // Error decode: misaligned and out-of-range.
        fetch(32'h002, 32'h0, 1'b1);
        fetch(32'h400, 32'h0, 1'b1);
        fetch(32'h040, 32'h0, 1'b1);
        prog(32'h42, 32'hFFFF_FFFF, 4'hF);
        prog(32'h40, 32'hFFFF_FFFF, 4'hF);
        fetch(32'h000, 32'h0, 1'b0);

        // Back-to-back fetches, one per cycle.
        prog(32'h10, 32'h0A0A_0A0A, 4'hF);
        prog(32'h14, 32'h0B0B_0B0B, 4'hF);
        b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h14; b2b_addr[2] = 32'h08;
        b2b_data[0] = 32'h0A0A_0A0A; b2b_data[1] = 32'h0B0B_0B0B; b2b_data[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = b2b_addr[i];
            #1;
            chk("b2b_ready", 64'(req_ready), 64'd1);
            q.push_back('{d: b2b_data[i], e: 1'b0});
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_last_valid", 64'(rsp_valid), 64'd1);
        prog(32'h14, 32'hFFFF_FFFF, 4'b1000);
        fetch(32'h14, 32'hFF0B_0B0B, 1'b0);

        // Stall with a pending response; same-index write must not disturb it.
        prog(32'h20, 32'h55AA_55AA, 4'hF);
        rsp_ready = 1'b0;
        req_addr = 32'h20; req_valid = 1'b1;
        #1;
        chk("stall_accept", 64'(req_ready), 64'd1);
        q.push_back('{d: 32'h55AA_55AA, e: 1'b0});
        @(posedge clk); #1;
        req_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_data", 64'(rsp_data), 64'h55AA_55AA);
            req_valid = (i < 4);
            if (i == 1) begin
                prog_we = 1'b1; prog_addr = 32'h20; prog_data = 32'h1111_1111; prog_be = 4'hF;
            end else begin
                prog_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("stall_data_end", 64'(rsp_data), 64'h55AA_55AA);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_drained", 64'(rsp_valid), 64'd0);
        fetch(32'h20, 32'h1111_1111, 1'b0);

        // Same-edge write and fetch: write-first byte merge.
        prog(32'h30, 32'h1234_5678, 4'hF);
        prog_we = 1'b1; prog_addr = 32'h30; prog_data = 32'hAABB_CCDD; prog_be = 4'h3;
        req_valid = 1'b1; req_addr = 32'h30;
        #1;
        chk("wf_ready", 64'(req_ready), 64'd1);
        q.push_back('{d: 32'h1234_CCDD, e: 1'b0});
        @(posedge clk); #1;
        prog_we = 1'b0; req_valid = 1'b0;
        fetch(32'h30, 32'h1234_CCDD, 1'b0);
        @(posedge clk); #1;

        // Reset in RUN with a response pending.
        rsp_ready = 1'b0;
        req_addr = 32'h8; req_valid = 1'b1;
        #1;
        chk("rr_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rr_valid", 64'(rsp_valid), 64'd1);
        chk("rr_data", 64'(rsp_data), 64'hDEAD_BEEF);
        #2;
        reset = 1'b0;
        #1;
        chk("rr_async_valid", 64'(rsp_valid), 64'd0);
        chk("rr_async_data", 64'(rsp_data), 64'd0);
        chk("rr_async_err", 64'(rsp_err), 64'd0);
        chk("rr_async_init", 64'(init_done), 64'd0);
        chk("rr_async_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        reset = 1'b1;
        wait_init("init2");
        fetch(32'h08, 32'h0, 1'b0);
        fetch(32'h30, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 256: words stored; SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_W, default 32: fetch and program address width.
REQ-004 Parameter BYTE_ADDR, default 1: 1 means byte addressing (index = addr[IDX_W+1:2]); 0 means word addressing (index = addr[IDX_W-1:0]).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  fetch request present.
REQ-008 req_ready  out  1  fetch request accepted this cycle.
REQ-009 req_addr  in  ADDR_W  fetch address.
REQ-010 rsp_valid  out  1  response holds data.
REQ-011 rsp_ready  in  1  consumer takes the response.
REQ-012 rsp_data  out  DATA_W  fetched word.
REQ-013 rsp_err  out  1  fetched address was out-of-range or misaligned.
REQ-014 prog_we  in  1  program-port write strobe.
REQ-015 prog_addr  in  ADDR_W  program address, decoded exactly as req_addr.
REQ-016 prog_data  in  DATA_W  program write data.
REQ-017 prog_be  in  DATA_W/8  per-byte write enables.
REQ-018 init_done  out  1  memory clear is complete; block is operational.

Function
REQ-019 The block SHALL have two states: CLEAR and RUN.
- CLEAR: an IDX_W-bit counter writes zero to one word per cycle, index 0 up to DEPTH-1.
- The state SHALL move to RUN on the cycle after index DEPTH-1 is written.
- init_done = 1 only in RUN.
REQ-020 In CLEAR, req_ready = 0 and prog_we is ignored.
REQ-021 In RUN, req_ready SHALL be 1 when (!rsp_valid || rsp_ready), i.e. when the response register is free or being freed this cycle.
REQ-022 A request is accepted when req_valid && req_ready. On that edge the response register loads, so rsp_valid rises one cycle later. Fetch latency is 1 cycle.
REQ-023 Back-to-back throughput: with rsp_ready held at 1, the block SHALL sustain one fetch per cycle.
REQ-024 While rsp_valid && !rsp_ready, rsp_data, rsp_err and rsp_valid SHALL stay unchanged.
REQ-025 If rsp_ready is 1 and no new request is accepted, rsp_valid SHALL clear on the next edge.
REQ-026 An address SHALL be flagged as an error when either:
- any bit above the index field is nonzero, or
- BYTE_ADDR=1 and addr[1:0] != 0.
For an errored fetch: rsp_err = 1, rsp_data = 0, and the memory is not read.
REQ-027 In RUN, prog_we SHALL write, on the clock edge, only the bytes whose prog_be bit is 1. A write to an errored address SHALL be dropped silently.
REQ-028 Same-edge program write and accepted fetch to the same index: the response SHALL return the post-write word, merged byte-wise (write-first).
REQ-029 A program write to the index held in a pending (stalled) response SHALL NOT alter rsp_data.
REQ-030 Index arithmetic SHALL be unsigned and IDX_W = log2(DEPTH) bits wide. The clear counter SHALL NOT wrap past DEPTH-1.

Reset
REQ-031 Asserting reset (low) at any time SHALL force, asynchronously:
- state = CLEAR, clear counter = 0;
- rsp_valid = 0, rsp_data = 0, rsp_err = 0;
- init_done = 0, req_ready = 0.
REQ-032 After reset is released, CLEAR SHALL run in full (DEPTH cycles) before init_done rises. A reset in the middle of CLEAR or RUN SHALL restart the clear from index 0.
REQ-033 The storage array SHALL NOT be reset asynchronously; it is zeroed only by CLEAR.

Structure
REQ-034 The shared package instr_mem_pkg SHALL hold:
- the state encoding (CLEAR=0, RUN=1);
- the default parameter values;
- the byte-offset width constant (2).
REQ-035 The storage array SHALL live in one sub-module, instr_mem_ram. It has one synchronous read port, one byte-enabled write port and write-first same-address behaviour. The top level holds the control, error decode, clear counter and response register.

Verification
REQ-036 Reset release with DEPTH=16 -> init_done rises exactly 16 cycles later; req_ready = 0 until then; a fetch of address 0x3C returns 0.
REQ-037 Program address 0x8 = 0xDEADBEEF with prog_be = 0xF, then fetch 0x8 with rsp_ready = 1 -> rsp_valid on the next cycle, rsp_data = 0xDEADBEEF, rsp_err = 0.
REQ-038 Fetches to 0x2 (misaligned) and to 0x400 with DEPTH=256 -> rsp_err = 1 and rsp_data = 0 for both.
REQ-039 Hold rsp_ready = 0 for 5 cycles with a response pending -> req_ready = 0 and rsp_data stable throughout. A same-index write of 0x11111111 in that window -> the stalled rsp_data is unchanged.
REQ-040 Same-edge program write 0xAABBCCDD with prog_be = 0x3 and fetch of the same word, which held 0x12345678 -> rsp_data = 0x1234CCDD.
REQ-041 Assert reset during RUN with rsp_valid = 1 -> rsp_valid drops immediately; clear restarts; the previously programmed word reads 0 after init_done.
